// File: rtl/bg_pic_writer.sv
// bg_pic_writer
//   Write side of the background-picture SDRAM channel. HPS ioctl bytes for
//   ioctl_index == BG_INDEX are paired into 16-bit words {odd, even} and
//   queued in a small FIFO. A req/ack FSM drains the FIFO into SDRAM ch1.
//   pic_valid tells the read-side fetcher that a complete picture is in SDRAM.
//
// Ports
//   clk, reset                      system clock, async active-high reset
//   ioctl_download/index/wr/addr/dout  HPS download byte stream
//   ioctl_wait                      backpressure to HPS (registered)
//   mem_req/mem_addr/mem_din        write request (level, held until mem_ack)
//   mem_ack                         one-cycle completion pulse
//   pic_valid                       picture fully written
//   word_count                      words written since download start
//   checksum                        running 16-bit word sum
//
// Build option
//   BG_PIC_WRITER_CHECKSUM_EN: when defined, checksum accumulates every word
//   written this download; otherwise checksum is tied to zero.

module bg_pic_writer #(
  parameter logic [7:0]  BG_INDEX   = 8'd2,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic              mem_ack,
  output logic              pic_valid,
  output logic [ADDR_W-1:0] word_count,
  output logic [15:0]       checksum
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ADDR_W + 16;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_POP
  } state_e;

  state_e            state_q, state_d;
  logic              active, active_rise, active_fall, strobe, lo_live;
  logic              active_q, active_d;
  logic [7:0]        lo_reg_q, lo_reg_d;
  logic [ADDR_W-1:0] lo_addr_q, lo_addr_d;
  logic              lo_valid_q, lo_valid_d;
  logic              push, push_ok, pop;
  logic [EW-1:0]     push_word, head;
  logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic              ioctl_wait_q, ioctl_wait_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic              pic_valid_q, pic_valid_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;

  assign active      = ioctl_download && (ioctl_index == BG_INDEX);
  assign active_rise = active && !active_q;
  assign active_fall = !active && active_q;
  assign strobe      = active && ioctl_wr;
  // A pending even byte from a previous download is dropped on a new start.
  assign lo_live     = lo_valid_q && !active_rise;
  assign active_d    = active;

  // Byte pairing. At most one push per cycle: the tail flush only happens
  // while Active is low, when no strobe is accepted.
  always_comb begin
    lo_reg_d   = lo_reg_q;
    lo_addr_d  = lo_addr_q;
    lo_valid_d = lo_live;
    push       = 1'b0;
    push_word  = '0;
    if (strobe) begin
      if (!ioctl_addr[0]) begin
        if (lo_live) begin
          push      = 1'b1;
          push_word = {lo_addr_q, 8'h00, lo_reg_q};
        end
        lo_reg_d   = ioctl_dout;
        lo_addr_d  = ioctl_addr[ADDR_W:1];
        lo_valid_d = 1'b1;
      end else begin
        push       = 1'b1;
        push_word  = {ioctl_addr[ADDR_W:1], ioctl_dout, (lo_live ? lo_reg_q : 8'h00)};
        lo_valid_d = 1'b0;
      end
    end else if (active_fall && lo_valid_q) begin
      push       = 1'b1;
      push_word  = {lo_addr_q, 8'h00, lo_reg_q};
      lo_valid_d = 1'b0;
    end
  end

  // FIFO bookkeeping; a push into a full FIFO is only kept if a pop frees a slot.
  always_comb begin
    pop     = (state_q == ST_POP);
    push_ok = push && ((fifo_cnt_q != FULL_LVL) || pop);
    head    = fifo_mem_q[rd_ptr_q];
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    ioctl_wait_d = (fifo_cnt_d >= WAIT_LVL);
  end

  // Write FSM. The head entry stays in the FIFO until its ack, so a request
  // abandoned by reset leaves nothing half-popped.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_cnt_q != '0) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = head[EW-1:16];
          mem_din_d  = head[15:0];
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d   = ST_POP;
          mem_req_d = 1'b0;
        end
      end
      ST_POP:  state_d = ST_IDLE;
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    word_count_d = word_count_q;
    pic_valid_d  = pic_valid_q;
    if (active_rise) begin
      word_count_d = '0;
      pic_valid_d  = 1'b0;
    end else begin
      if (pop) word_count_d = word_count_q + 1'b1;
      // active_q low too, so a tail flushed on the falling edge is already queued.
      if (!active && !active_q && (fifo_cnt_q == '0) && (state_q == ST_IDLE) &&
          (word_count_q != '0))
        pic_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      active_q     <= 1'b0;
      lo_reg_q     <= '0;
      lo_addr_q    <= '0;
      lo_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      ioctl_wait_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      pic_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      lo_reg_q     <= lo_reg_d;
      lo_addr_q    <= lo_addr_d;
      lo_valid_q   <= lo_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      ioctl_wait_q <= ioctl_wait_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      pic_valid_q  <= pic_valid_d;
      word_count_q <= word_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= push_word;
  end

`ifdef BG_PIC_WRITER_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (active_rise)  checksum_d = '0;
    else if (pop)     checksum_d = checksum_q + mem_din_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign ioctl_wait = ioctl_wait_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign pic_valid  = pic_valid_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_bg_pic_writer.sv
module tb_bg_pic_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack;
  logic        pic_valid;
  logic [23:0] word_count;
  logic [15:0] checksum;

  bg_pic_writer #(.BG_INDEX(8'd2), .ADDR_W(24), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
    .pic_valid(pic_valid), .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // SDRAM responder / protocol monitor state
  int          ack_lat   = 2;
  int          wait_cnt  = 0;
  int          since_ack = 99;
  int          viol      = 0;
  bit          saw_wait  = 0;
  bit          saw_req   = 0;
  logic        prev_req  = 1'b0;
  logic [39:0] prev_word = '0;
  logic [39:0] got_q[$];

  // Reference stimulus and expectations
  logic [24:0] b_addr[$];
  logic [7:0]  b_data[$];
  logic [39:0] exp_q[$];

  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        mem_ack = 1'b0; wait_cnt = 0; prev_req = 1'b0; since_ack = 99;
      end else begin
        if (since_ack < 3) since_ack++;
        if ((since_ack == 1 || since_ack == 2) && mem_req) viol++;
        if (prev_req && mem_req && ({mem_addr, mem_din} !== prev_word)) viol++;
        prev_req  = mem_req;
        prev_word = {mem_addr, mem_din};
        if (ioctl_wait) saw_wait = 1;
        if (mem_req) saw_req = 1;
        if (mem_ack) mem_ack = 1'b0;
        else if (mem_req) begin
          if (wait_cnt >= ack_lat) begin
            mem_ack = 1'b1;
            got_q.push_back({mem_addr, mem_din});
            wait_cnt = 0;
            since_ack = 0;
          end else wait_cnt++;
        end else wait_cnt = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 5ms");
    $fatal(1);
  end

  // Picture words from the byte stream: odd byte closes a word with any
  // pending even byte, a lone even byte becomes {00, even} at its own word.
  task automatic build_expected();
    logic [7:0]  lo = '0;
    logic [23:0] lo_a = '0;
    bit          lv = 0;
    exp_q.delete();
    foreach (b_addr[i]) begin
      if (b_addr[i][0] == 1'b0) begin
        if (lv) exp_q.push_back({lo_a, 8'h00, lo});
        lo = b_data[i]; lo_a = b_addr[i][24:1]; lv = 1;
      end else begin
        exp_q.push_back({b_addr[i][24:1], b_data[i], (lv ? lo : 8'h00)});
        lv = 0;
      end
    end
    if (lv) exp_q.push_back({lo_a, 8'h00, lo});
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int t = 0;
    while (ioctl_wait && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL ioctl_wait_timeout: wait=%0b, required low within 500 cycles", ioctl_wait);
    end
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic run_download(input string name, input int lat);
    logic [15:0] sum = '0;
    int t = 0;
    ack_lat = lat; got_q.delete(); viol = 0;
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pic_valid !== 1'b0) begin n_fail++;
      $display("FAIL %s_pic_clear: pic_valid=%0b, required 0", name, pic_valid); end
    foreach (b_addr[i]) send_byte(b_addr[i], b_data[i]);
    ioctl_download = 1'b0;
    while (!pic_valid && t < 3000) begin @(negedge clk); t++; end
    n_checks++;
    if (pic_valid !== 1'b1) begin n_fail++;
      $display("FAIL %s_pic_valid: pic_valid=%0b, required 1", name, pic_valid); end
    build_expected();
    foreach (exp_q[i]) sum += exp_q[i][15:0];
`ifndef BG_PIC_WRITER_CHECKSUM_EN
    sum = 16'h0000;
`endif
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++;
      $display("FAIL %s_nwrites: got %0d, required %0d", name, got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++;
          $display("FAIL %s_write%0d: got addr=%h data=%h, required addr=%h data=%h",
                   name, i, got_q[i][39:16], got_q[i][15:0], exp_q[i][39:16], exp_q[i][15:0]);
        end
      end
    end
    n_checks++;
    if (word_count !== 24'(exp_q.size())) begin n_fail++;
      $display("FAIL %s_word_count: got %0d, required %0d", name, word_count, exp_q.size()); end
    n_checks++;
    if (checksum !== sum) begin n_fail++;
      $display("FAIL %s_checksum: got %h, required %h", name, checksum, sum); end
    n_checks++;
    if (viol != 0) begin n_fail++;
      $display("FAIL %s_protocol: %0d req violations, required 0", name, viol); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req, ioctl_wait, pic_valid} !== 3'b000 || word_count !== 24'd0 || checksum !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: req=%0b wait=%0b pv=%0b wc=%0d cs=%h, required all zero",
               mem_req, ioctl_wait, pic_valid, word_count, checksum);
    end
  endtask

  task automatic test_other_index();
    saw_req = 0; got_q.delete();
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(8'h50 + i));
    ioctl_download = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (saw_req !== 1'b0 || got_q.size() != 0) begin n_fail++;
      $display("FAIL other_index_req: saw_req=%0b writes=%0d, required 0 and 0", saw_req, got_q.size()); end
    n_checks++;
    if (pic_valid !== 1'b0) begin n_fail++;
      $display("FAIL other_index_pic: pic_valid=%0b, required 0", pic_valid); end
  endtask

  task automatic test_basic();
    b_addr = '{25'd0, 25'd1, 25'd2, 25'd3};
    b_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_download("basic", 2);
    n_checks++;
    if (got_q.size() < 2 || got_q[0] !== {24'd0, 16'h2211} || got_q[1] !== {24'd1, 16'h4433}) begin
      n_fail++;
      $display("FAIL basic_const: writes=%0d, required (0,2211),(1,4433)", got_q.size());
    end
  endtask

  task automatic test_odd_tail();
    b_addr = '{25'd0, 25'd1, 25'd2};
    b_data = '{8'hAA, 8'hBB, 8'hCC};
    run_download("tail", 1);
    n_checks++;
    if (got_q.size() != 2 || got_q[1] !== {24'd1, 16'h00CC}) begin n_fail++;
      $display("FAIL tail_const: writes=%0d, required 2 ending (1,00CC)", got_q.size()); end
  endtask

  task automatic test_backpressure();
    b_addr.delete(); b_data.delete();
    for (int i = 0; i < 16; i++) begin
      b_addr.push_back(25'(i)); b_data.push_back(8'($urandom));
    end
    saw_wait = 0;
    run_download("backpressure", 20);
    n_checks++;
    if (saw_wait !== 1'b1) begin n_fail++;
      $display("FAIL backpressure_wait: saw ioctl_wait=%0b, required 1", saw_wait); end
  endtask

  task automatic test_checksum();
    logic [15:0] req;
    b_addr = '{25'd0, 25'd1, 25'd2, 25'd3};
    b_data = '{8'hFF, 8'hFF, 8'h02, 8'h00};
    run_download("checksum", 1);
`ifdef BG_PIC_WRITER_CHECKSUM_EN
    req = 16'h0001;
`else
    req = 16'h0000;
`endif
    n_checks++;
    if (checksum !== req) begin n_fail++;
      $display("FAIL checksum_const: got %h, required %h", checksum, req); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int w = int'($urandom_range(0, 1000));
      int n = int'($urandom_range(2, 8));
      b_addr.delete(); b_data.delete();
      for (int s = 0; s < n; s++) begin
        int kind = int'($urandom_range(0, 3));
        if (kind <= 2) begin b_addr.push_back(25'(2 * w));     b_data.push_back(8'($urandom)); end
        if (kind != 2) begin b_addr.push_back(25'(2 * w + 1)); b_data.push_back(8'($urandom)); end
        w++;
      end
      run_download($sformatf("random%0d", it), int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_reset_mid();
    ack_lat = 100000;
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) send_byte(25'(i), 8'(8'hA0 + i));
    repeat (3) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || ioctl_wait !== 1'b1) begin n_fail++;
      $display("FAIL resetmid_pre: req=%0b wait=%0b, required 1 and 1", mem_req, ioctl_wait); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++;
      $display("FAIL resetmid_req_drop: mem_req=%0b, required 0", mem_req); end
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ack_lat = 2; saw_req = 0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (saw_req !== 1'b0 || ioctl_wait !== 1'b0 || pic_valid !== 1'b0 || word_count !== 24'd0) begin
      n_fail++;
      $display("FAIL resetmid_post: saw_req=%0b wait=%0b pv=%0b wc=%0d, required all zero",
               saw_req, ioctl_wait, pic_valid, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_other_index();
    test_basic();
    test_odd_tail();
    test_backpressure();
    test_checksum();
    test_random();
    test_reset_mid();
    test_basic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
